// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, FSM state type and BCD check for the time-of-day counter
package rtc_pkg;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] HR_MAX  = 8'h23;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  // For well-formed BCD, numeric ordering matches decimal ordering, so a plain compare bounds the value.
  function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max_bcd);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_bcd);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter that wraps at MAX_BCD and flags the wrap combinationally
module bcd_mod_counter #(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q, value_d;

  // Combinational wrap lets the next digit pair advance on the same edge.
  assign wrap  = inc && !load && (value_q == MAX_BCD);
  assign value = value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      if (value_q == MAX_BCD) begin
        value_d = 8'h00;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/rtc_hms_counter.sv
// rtl/rtc_hms_counter.sv - BCD hh:mm:ss time-of-day counter with 1 Hz enable prescaler and load port
module rtc_hms_counter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk_100m,
  input  logic       rst,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic       set_ready,
  output logic       set_err,
  output logic       tick_1hz,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       carry_day
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          carry_q, carry_d;

  logic accept, fields_ok, load_ok, counting, sec_inc;
  logic sec_wrap, min_wrap, hr_wrap;

  assign accept    = set_valid && set_ready;
  assign fields_ok = bcd_valid(set_ss, SEC_MAX) && bcd_valid(set_mm, MIN_MAX) &&
                     bcd_valid(set_hh, HR_MAX);
  assign load_ok   = accept && fields_ok;
  assign counting  = run && (state_q == S_RUN);
  // Any accepted load, valid or not, swallows a coincident second advance.
  assign sec_inc   = counting && (pre_q == PRE_LAST) && !accept;

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    set_ready = (state_q == S_RUN);
  end

  always_comb begin
    pre_d = pre_q;
    if (load_ok) begin
      pre_d = '0;
    end else if (counting && !accept) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
    tick_d  = sec_inc;
    err_d   = accept && !fields_ok;
    carry_d = hr_wrap;
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      carry_q <= carry_d;
    end
  end

  assign tick_1hz  = tick_q;
  assign set_err   = err_q;
  assign carry_day = carry_q;

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .clk_100m (clk_100m),
    .rst      (rst),
    .inc      (sec_inc),
    .load     (load_ok),
    .load_val (set_ss),
    .value    (ss),
    .wrap     (sec_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .clk_100m (clk_100m),
    .rst      (rst),
    .inc      (sec_wrap),
    .load     (load_ok),
    .load_val (set_mm),
    .value    (mm),
    .wrap     (min_wrap)
  );

  bcd_mod_counter #(.MAX_BCD(HR_MAX)) u_hr (
    .clk_100m (clk_100m),
    .rst      (rst),
    .inc      (min_wrap),
    .load     (load_ok),
    .load_val (set_hh),
    .value    (hh),
    .wrap     (hr_wrap)
  );

endmodule

// File: tb/tb_rtc_hms_counter.sv
// tb/tb_rtc_hms_counter.sv - directed self-checking bench for rtc_hms_counter with TICK_DIV=4
module tb_rtc_hms_counter;

  logic       clk_100m = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic       set_ready, set_err, tick_1hz, carry_day;
  logic [7:0] hh, mm, ss;

  int checks = 0;
  int errors = 0;

  rtc_hms_counter #(.TICK_DIV(4)) dut (
    .clk_100m  (clk_100m),
    .rst       (rst),
    .run       (run),
    .set_valid (set_valid),
    .set_hh    (set_hh),
    .set_mm    (set_mm),
    .set_ss    (set_ss),
    .set_ready (set_ready),
    .set_err   (set_err),
    .tick_1hz  (tick_1hz),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .carry_day (carry_day)
  );

  always #5 clk_100m = ~clk_100m;

  task automatic step();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_valid = 1'b0;
    run = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_tick(input int max_cycles, output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      step();
      cycles++;
      if (tick_1hz === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({hh, mm, ss} !== 24'h000000 || tick_1hz !== 1'b0 || set_err !== 1'b0 ||
        carry_day !== 1'b0 || set_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_initial: got hms=%h tick=%b err=%b carry=%b ready=%b, want 000000 0 0 0 1",
               {hh, mm, ss}, tick_1hz, set_err, carry_day, set_ready);
    end
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 14; i++) step();
    checks++;
    if ({hh, mm, ss} !== 24'h000003) begin
      errors++;
      $display("FAIL reset_precount: got hms=%h want 000003", {hh, mm, ss});
    end
    // Prescaler now sits at 2; reset lands between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({hh, mm, ss} !== 24'h000000 || tick_1hz !== 1'b0 || set_err !== 1'b0 ||
        carry_day !== 1'b0 || set_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midcount: got hms=%h tick=%b err=%b carry=%b ready=%b, want 000000 0 0 0 1",
               {hh, mm, ss}, tick_1hz, set_err, carry_day, set_ready);
    end
    step();
    rst = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_counting();
    logic       exp_tick;
    logic [7:0] exp_ss;
    int         n;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      n = i / 4;
      exp_tick = (i % 4 == 0);
      exp_ss = {4'(n / 10), 4'(n % 10)};
      checks++;
      if (tick_1hz !== exp_tick || ss !== exp_ss || mm !== 8'h00 || hh !== 8'h00) begin
        errors++;
        $display("FAIL counting cycle %0d: got tick=%b hms=%h want tick=%b hms=0000%h",
                 i, tick_1hz, {hh, mm, ss}, exp_tick, exp_ss);
      end
    end
  endtask

  task automatic test_day_wrap();
    int cyc;
    bit seen;
    do_reset();
    run = 1'b1;
    set_hh = 8'h23; set_mm = 8'h59; set_ss = 8'h58;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if ({hh, mm, ss} !== 24'h235958 || set_ready !== 1'b0 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL daywrap_load: got hms=%h ready=%b err=%b want 235958 0 0",
               {hh, mm, ss}, set_ready, set_err);
    end
    step();
    checks++;
    if (set_ready !== 1'b1) begin
      errors++;
      $display("FAIL daywrap_ready_back: got ready=%b want 1", set_ready);
    end
    wait_tick(8, cyc, seen);
    checks++;
    if (!seen || cyc != 4 || {hh, mm, ss} !== 24'h235959 || carry_day !== 1'b0) begin
      errors++;
      $display("FAIL daywrap_tick1: got seen=%b cycles=%0d hms=%h carry=%b want 1 4 235959 0",
               seen, cyc, {hh, mm, ss}, carry_day);
    end
    wait_tick(8, cyc, seen);
    checks++;
    if (!seen || cyc != 4 || {hh, mm, ss} !== 24'h000000 || carry_day !== 1'b1) begin
      errors++;
      $display("FAIL daywrap_tick2: got seen=%b cycles=%0d hms=%h carry=%b want 1 4 000000 1",
               seen, cyc, {hh, mm, ss}, carry_day);
    end
    step();
    checks++;
    if (carry_day !== 1'b0 || tick_1hz !== 1'b0) begin
      errors++;
      $display("FAIL daywrap_pulse_len: got carry=%b tick=%b want 0 0", carry_day, tick_1hz);
    end
  endtask

  task automatic test_invalid_loads();
    logic [23:0] bad [2];
    bad[0] = 24'h10205A;
    bad[1] = 24'h242030;
    do_reset();
    run = 1'b0;
    {set_hh, set_mm, set_ss} = 24'h102030;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if ({hh, mm, ss} !== 24'h102030 || set_err !== 1'b0) begin
      errors++;
      $display("FAIL invalid_setup: got hms=%h err=%b want 102030 0", {hh, mm, ss}, set_err);
    end
    step();
    for (int k = 0; k < 2; k++) begin
      {set_hh, set_mm, set_ss} = bad[k];
      set_valid = 1'b1;
      step();
      set_valid = 1'b0;
      checks++;
      if (set_err !== 1'b1 || {hh, mm, ss} !== 24'h102030 || set_ready !== 1'b0) begin
        errors++;
        $display("FAIL invalid_%0d: got err=%b hms=%h ready=%b want 1 102030 0",
                 k, set_err, {hh, mm, ss}, set_ready);
      end
      step();
      checks++;
      if (set_err !== 1'b0 || {hh, mm, ss} !== 24'h102030) begin
        errors++;
        $display("FAIL invalid_%0d_after: got err=%b hms=%h want 0 102030", k, set_err, {hh, mm, ss});
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    run = 1'b1;
    step();
    step();
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (tick_1hz !== 1'b0 || ss !== 8'h00) begin
        errors++;
        $display("FAIL pause_hold %0d: got tick=%b ss=%h want 0 00", i, tick_1hz, ss);
      end
    end
    run = 1'b1;
    step();
    checks++;
    if (tick_1hz !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume1: got tick=%b want 0", tick_1hz);
    end
    step();
    checks++;
    if (tick_1hz !== 1'b1 || ss !== 8'h01) begin
      errors++;
      $display("FAIL pause_resume2: got tick=%b ss=%h want 1 01", tick_1hz, ss);
    end
  endtask

  task automatic test_collision();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 27; i++) step();
    checks++;
    if ({hh, mm, ss} !== 24'h000006) begin
      errors++;
      $display("FAIL collide_pre: got hms=%h want 000006", {hh, mm, ss});
    end
    // Prescaler is at its last count: this edge would have shown 00:00:07.
    {set_hh, set_mm, set_ss} = 24'h123456;
    set_valid = 1'b1;
    step();
    set_valid = 1'b0;
    checks++;
    if ({hh, mm, ss} !== 24'h123456 || tick_1hz !== 1'b0 || carry_day !== 1'b0) begin
      errors++;
      $display("FAIL collide_load: got hms=%h tick=%b carry=%b want 123456 0 0",
               {hh, mm, ss}, tick_1hz, carry_day);
    end
    // One held S_LOAD cycle, then TICK_DIV cycles of counting.
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (tick_1hz !== 1'b0) begin
        errors++;
        $display("FAIL collide_quiet %0d: got tick=%b want 0", i, tick_1hz);
      end
    end
    step();
    checks++;
    if (tick_1hz !== 1'b1 || {hh, mm, ss} !== 24'h123457) begin
      errors++;
      $display("FAIL collide_next_tick: got tick=%b hms=%h want 1 123457", tick_1hz, {hh, mm, ss});
    end
  endtask

  initial begin
    test_reset();
    test_counting();
    test_day_wrap();
    test_invalid_loads();
    test_pause();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
